// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the pc sequencer: FSM states, branch kinds, condition codes.
// Also provides cond_true(), the NZCV condition evaluator reused by the execute stage.
// Pure declarations; no logic or timing of its own.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } seq_state_t;

  typedef enum logic [1:0] {
    BR_JMP  = 2'b00,
    BR_JREL = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_kind_t;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // flags are packed {N,Z,C,V}
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, r;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      CC_EQ:   r = z;
      CC_NE:   r = !z;
      CC_CS:   r = c;
      CC_CC:   r = !c;
      CC_MI:   r = n;
      CC_PL:   r = !n;
      CC_VS:   r = v;
      CC_VC:   r = !v;
      CC_HI:   r = c && !z;
      CC_LS:   r = !c || z;
      CC_GE:   r = (n == v);
      CC_LT:   r = (n != v);
      CC_GT:   r = !z && (n == v);
      CC_LE:   r = z || (n != v);
      CC_AL:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between decode/execute, the pc sequencer and instruction fetch.
// master = decode/execute side driving requests; slave = the sequencer.
// No flow control: requests are sampled every cycle, dropped requests are not retried.
interface pc_sequencer_if #(
  parameter int A = 16
);
  logic         en;
  logic         stall;
  logic         halt;
  logic         br_valid;
  logic [1:0]   br_kind;
  logic [3:0]   br_cond;
  logic [A-1:0] br_target;
  logic [3:0]   flags;
  logic [A-1:0] pc;
  logic         pc_valid;
  logic [1:0]   state;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_err;

  modport master (
    output en, stall, halt, br_valid, br_kind, br_cond, br_target, flags,
    input  pc, pc_valid, state, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  en, stall, halt, br_valid, br_kind, br_cond, br_target, flags,
    output pc, pc_valid, state, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO, DEPTH x A; dout always shows the current top entry.
// Push/pop take effect on the next edge; dout is combinational from the registered pointer.
// Push when full and pop when empty are ignored; callers never push and pop together.
module pc_sequencer_ret_stack #(
  parameter int A     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [A-1:0] din,
  output logic [A-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] sp_q;
  logic [A-1:0]  mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  // Low bits of the pointer address the array; the extra bit distinguishes full from empty.
  assign wr_idx  = sp_q[IW-1:0];
  assign top_idx = sp_q[IW-1:0] - IW'(1);
  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign dout    = mem[top_idx];

  // Stack pointer: count up on push, down on pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - PW'(1);
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential advance, conditional jump/relative/call/return.
// Branches take effect one edge after the request is sampled.
// stall or en=0 holds pc and drops any branch request; halt freezes until reset.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int A         = 16,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int DEPTH     = 4
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);
  seq_state_t   state_q, state_d;
  br_kind_t     kind;
  logic [A-1:0] pc_q, pc_d, pc_inc, stk_dout;
  logic         stk_full, stk_empty, err_q;
  logic         advance, taken, push, pop, err_set;

  assign kind = br_kind_t'(bus.br_kind);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt wins from IDLE and RUN; HALT is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.halt)    state_d = ST_HALT;
        else if (bus.en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt)    state_d = ST_HALT;
      end
      default: state_d = state_q;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.pc_valid = (state_q == ST_RUN);
    bus.state    = state_q;
  end

  // Next pc and stack control. A CALL on a full stack or RET on an empty one
  // degrades to a sequential advance and flags the error.
  always_comb begin
    advance = (state_q == ST_RUN) && !bus.halt && !bus.stall && bus.en;
    taken   = advance && bus.br_valid && cond_true(bus.br_cond, bus.flags);
    push    = taken && (kind == BR_CALL) && !stk_full;
    pop     = taken && (kind == BR_RET) && !stk_empty;
    err_set = taken && (((kind == BR_CALL) && stk_full) || ((kind == BR_RET) && stk_empty));
    pc_inc  = pc_q + A'(STEP);
    pc_d    = pc_q;
    if (advance) begin
      pc_d = pc_inc;
      if (taken) begin
        case (kind)
          BR_JMP:  pc_d = bus.br_target;
          BR_JREL: pc_d = pc_q + bus.br_target;
          BR_CALL: if (!stk_full) pc_d = bus.br_target;
          BR_RET:  if (!stk_empty) pc_d = stk_dout;
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  // pc register and sticky stack error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= A'(RESET_VEC);
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  pc_sequencer_ret_stack #(
    .A     (A),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Outward status.
  always_comb begin
    bus.pc          = pc_q;
    bus.stack_full  = stk_full;
    bus.stack_empty = stk_empty;
    bus.stack_err   = err_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed corner sequences, a condition-code vector table,
// and randomized traffic against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pc_sequencer;
  localparam int A = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  pc_sequencer_if #(.A(A)) bus ();

  pc_sequencer #(.A(A), .STEP(1), .RESET_VEC(0), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_state;
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_err;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    bit         taken;
  } cc_vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Condition pairs: even code is the base test, odd code its negation.
  function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cy;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cy && !z;
      3'd5:    b = (n == v);
      3'd6:    b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = 16'h0000;
    m_stk.delete();
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit tk;
    if (m_state == 0) begin
      if (bus.halt) m_state = 2;
      else if (bus.en) m_state = 1;
    end else if (m_state == 1) begin
      if (bus.halt) m_state = 2;
      else if (bus.stall || !bus.en) begin
      end else begin
        tk = bus.br_valid && cond_ref(bus.br_cond, bus.flags);
        if (!tk) m_pc = m_pc + 16'd1;
        else begin
          case (bus.br_kind)
            2'd0: m_pc = bus.br_target;
            2'd1: m_pc = m_pc + bus.br_target;
            2'd2: begin
              if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 16'd1);
                m_pc = bus.br_target;
              end else begin
                m_pc = m_pc + 16'd1;
                m_err = 1'b1;
              end
            end
            default: begin
              if (m_stk.size() > 0) m_pc = m_stk.pop_back();
              else begin
                m_pc = m_pc + 16'd1;
                m_err = 1'b1;
              end
            end
          endcase
        end
      end
    end
  endtask

  task automatic compare_model();
    check("pc",          32'(bus.pc),          32'(m_pc));
    check("pc_valid",    32'(bus.pc_valid),    32'(m_state == 1));
    check("state",       32'(bus.state),       32'(m_state));
    check("stack_full",  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
    check("stack_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
    check("stack_err",   32'(bus.stack_err),   32'(m_err));
  endtask

  task automatic drive(input logic en, input logic stall, input logic halt, input logic bv,
                       input logic [1:0] kind, input logic [3:0] cond,
                       input logic [15:0] tgt, input logic [3:0] flags);
    bus.en = en; bus.stall = stall; bus.halt = halt; bus.br_valid = bv;
    bus.br_kind = kind; bus.br_cond = cond; bus.br_target = tgt; bus.flags = flags;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 2'd0, 4'd0, 16'h0, 4'h0);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  cc_vec_t tbl[19];

  initial begin
    tbl[0]  = '{4'd0,  4'b0100, 1'b1};  // EQ, Z=1
    tbl[1]  = '{4'd0,  4'b0000, 1'b0};  // EQ, Z=0
    tbl[2]  = '{4'd15, 4'b1111, 1'b0};  // NV
    tbl[3]  = '{4'd12, 4'b1001, 1'b1};  // GT, N=V=1, Z=0
    tbl[4]  = '{4'd12, 4'b1101, 1'b0};  // GT, Z=1
    tbl[5]  = '{4'd1,  4'b0000, 1'b1};  // NE
    tbl[6]  = '{4'd2,  4'b0010, 1'b1};  // CS
    tbl[7]  = '{4'd3,  4'b0010, 1'b0};  // CC
    tbl[8]  = '{4'd4,  4'b1000, 1'b1};  // MI
    tbl[9]  = '{4'd5,  4'b1000, 1'b0};  // PL
    tbl[10] = '{4'd6,  4'b0001, 1'b1};  // VS
    tbl[11] = '{4'd7,  4'b0000, 1'b1};  // VC
    tbl[12] = '{4'd8,  4'b0010, 1'b1};  // HI
    tbl[13] = '{4'd8,  4'b0110, 1'b0};  // HI with Z
    tbl[14] = '{4'd9,  4'b0110, 1'b1};  // LS
    tbl[15] = '{4'd10, 4'b1001, 1'b1};  // GE
    tbl[16] = '{4'd11, 4'b1000, 1'b1};  // LT
    tbl[17] = '{4'd13, 4'b0100, 1'b1};  // LE
    tbl[18] = '{4'd14, 4'b0000, 1'b1};  // AL

    drive(0, 0, 0, 0, 2'd0, 4'd0, 16'h0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    32'(bus.pc), 32'h0);
    check("rst_valid", 32'(bus.pc_valid), 32'h0);
    check("rst_state", 32'(bus.state), 32'h0);
    check("rst_full",  32'(bus.stack_full), 32'h0);
    check("rst_empty", 32'(bus.stack_empty), 32'h1);
    check("rst_err",   32'(bus.stack_err), 32'h0);
    reset = 1'b1;

    // Reset and run
    drive(1, 0, 0, 0, 2'd0, 4'd0, 16'h0, 4'h0);
    tick();
    check("run_first_pc",    32'(bus.pc), 32'h0);
    check("run_first_valid", 32'(bus.pc_valid), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("run_seq_pc", 32'(bus.pc), 32'(i));
    end

    // Condition table: jump to 5, then JMP 0x40 with each cond/flags pair
    foreach (tbl[i]) begin
      drive(1, 0, 0, 1, 2'd0, 4'd14, 16'h0005, 4'h0);
      tick();
      drive(1, 0, 0, 1, 2'd0, tbl[i].cond, 16'h0040, tbl[i].flags);
      tick();
      check("cc_vec_pc", 32'(bus.pc), tbl[i].taken ? 32'h40 : 32'h6);
    end

    // Relative wrap and sequential wrap
    drive(1, 0, 0, 1, 2'd0, 4'd14, 16'h0002, 4'h0); tick();
    drive(1, 0, 0, 1, 2'd1, 4'd14, 16'hFFFC, 4'h0); tick();
    check("jrel_wrap", 32'(bus.pc), 32'hFFFE);
    drive(1, 0, 0, 1, 2'd0, 4'd14, 16'hFFFF, 4'h0); tick();
    drive(1, 0, 0, 0, 2'd0, 4'd14, 16'h0000, 4'h0); tick();
    check("seq_wrap", 32'(bus.pc), 32'h0000);

    // Call/return nesting
    drive(1, 0, 0, 1, 2'd0, 4'd14, 16'd10, 4'h0); tick();
    for (int i = 2; i <= 5; i++) begin
      drive(1, 0, 0, 1, 2'd2, 4'd14, 16'(i * 10), 4'h0); tick();
    end
    check("call4_pc",   32'(bus.pc), 32'd50);
    check("call4_full", 32'(bus.stack_full), 32'h1);
    check("call4_err",  32'(bus.stack_err), 32'h0);
    drive(1, 0, 0, 1, 2'd2, 4'd14, 16'd99, 4'h0); tick();
    check("call5_pc",  32'(bus.pc), 32'd51);
    check("call5_err", 32'(bus.stack_err), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      drive(1, 0, 0, 1, 2'd3, 4'd14, 16'h0, 4'h0); tick();
      check("ret_pc", 32'(bus.pc), 32'(i * 10 + 1));
    end
    check("ret_empty", 32'(bus.stack_empty), 32'h1);
    drive(1, 0, 0, 1, 2'd3, 4'd14, 16'h0, 4'h0); tick();
    check("ret_under_pc",  32'(bus.pc), 32'd12);
    check("ret_under_err", 32'(bus.stack_err), 32'h1);

    // Stall drops the branch
    drive(1, 1, 0, 1, 2'd0, 4'd14, 16'h0080, 4'h0); tick();
    check("stall_pc", 32'(bus.pc), 32'd12);
    drive(1, 0, 0, 0, 2'd0, 4'd14, 16'h0080, 4'h0); tick();
    check("stall_drop_pc", 32'(bus.pc), 32'd13);

    // Halt beats a jump and sticks
    drive(1, 0, 1, 1, 2'd0, 4'd14, 16'h0080, 4'h0); tick();
    check("halt_state", 32'(bus.state), 32'h2);
    check("halt_pc",    32'(bus.pc), 32'd13);
    check("halt_valid", 32'(bus.pc_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 2'd0, 4'd14, 16'h0090, 4'h0); tick();
      check("halt_hold_pc", 32'(bus.pc), 32'd13);
    end

    // Randomized traffic against the model, with one asynchronous mid-run reset
    for (int blk = 0; blk < 10; blk++) begin
      do_reset();
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (blk == 3 && cyc == 100) begin
          reset = 1'b0;
          #1;
          check("async_rst_pc",    32'(bus.pc), 32'h0);
          check("async_rst_state", 32'(bus.state), 32'h0);
          check("async_rst_valid", 32'(bus.pc_valid), 32'h0);
          model_reset();
          @(posedge clk);
          #1;
          reset = 1'b1;
        end
        drive($urandom_range(7) != 0, $urandom_range(7) == 0, $urandom_range(199) == 0,
              $urandom_range(1) == 1, 2'($urandom_range(3)),
              ($urandom_range(2) == 0) ? 4'd14 : 4'($urandom_range(15)),
              16'($urandom), 4'($urandom_range(15)));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer. Replaces the free-running bench counter that currently drives the processor's instruction address.
- Generates the fetch address each cycle and supports stall, halt, conditional branches, and call/return through an internal return-address stack.
- Condition evaluation uses the processor's 4-bit Cond field and NZCV flags.
- Sits between the decode/execute stage (branch requests, flags) and instruction memory (pc).

Parameters:
- A, 16: address width in bits.
- STEP, 1: increment applied on sequential advance.
- RESET_VEC, 0: pc value loaded on reset.
- DEPTH, 4: return-stack entries (power of 2, at least 2).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: run enable; starts the sequencer from IDLE and gates advance while in RUN.
- stall, input, 1: hold pc this cycle.
- halt, input, 1: enter HALT.
- br_valid, input, 1: branch request present this cycle.
- br_kind, input, 2: 00 = JMP absolute, 01 = JREL relative, 10 = CALL, 11 = RET.
- br_cond, input, 4: condition code.
- br_target, input, A: absolute target, or two's-complement offset for JREL.
- flags, input, 4: {N,Z,C,V}.
- pc, output, A: current fetch address.
- pc_valid, output, 1: pc is a fetch address to be used this cycle.
- state, output, 2: 00 = IDLE, 01 = RUN, 10 = HALT.
- stack_full, output, 1: stack holds DEPTH entries.
- stack_empty, output, 1: stack holds 0 entries.
- stack_err, output, 1: sticky flag for overflow/underflow.

Behaviour:
- Reset (asynchronous, active-low, effective immediately, including mid-operation): pc = RESET_VEC, pc_valid = 0, state = IDLE, stack pointer = 0, stack_empty = 1, stack_full = 0, stack_err = 0.
- State machine transitions:
  - IDLE goes to RUN on a clk edge with en = 1. halt in IDLE also goes to HALT.
  - RUN goes to HALT on a clk edge with halt = 1.
  - HALT is exited only by reset.
- pc_valid is 1 exactly while state = RUN. In HALT, pc holds its last value.
- RUN update priority per edge, highest first:
  - halt: pc holds.
  - stall = 1 or en = 0: pc holds, and the branch request is ignored (it is not queued).
  - br_valid = 1 with the condition true: branch.
  - Otherwise: pc <= pc + STEP.
- Branch latency is 1 cycle: a request sampled at edge k makes pc = target after edge k.
- Condition table (flags = N,Z,C,V):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- A false condition is treated exactly as no request: pc += STEP, and the stack is untouched.
- JMP: pc <= br_target.
- JREL: pc <= pc + br_target, both A bits, two's complement, modulo 2^A.
- CALL:
  - Not full: push pc+STEP, then pc <= br_target.
  - Full: no push, no branch, pc += STEP, stack_err <= 1.
- RET:
  - Not empty: pop; pc <= popped value.
  - Empty: no pop, pc += STEP, stack_err <= 1.
- All pc arithmetic wraps modulo 2^A.
- stack_full and stack_empty reflect the registered stack pointer.
- stack_err clears only on reset.

Decomposition:
- Shared package holds:
  - State encodings IDLE/RUN/HALT.
  - br_kind encodings.
  - The 16 condition-code constants.
  - A cond_true(cond, flags) function shared with the execute stage.
- One sub-module: ret_stack, a LIFO of DEPTH x A.
  - Inputs: push, pop, din.
  - Outputs: dout (top of stack), full, empty.
  - Simultaneous push and pop is illegal and never issued by pc_sequencer.

Test Plan:
- Reset and run: RESET_VEC = 0; release reset, en = 1 for 4 edges → pc sequence 0, 1, 2, 3, 4; pc_valid = 1 from the first RUN cycle. Reassert reset mid-run → pc = 0 and state = IDLE immediately, without waiting for an edge.
- Conditional branches:
  - At pc = 5, JMP target 0x40 with cond EQ and Z = 1 → pc = 0x40 next cycle.
  - Same request with Z = 0 → pc = 6.
  - cond NV → pc = 6.
  - GT with N = 1, V = 1, Z = 0 → taken.
- Relative wrap: A = 16, pc = 0x0002, JREL with target 0xFFFC, cond AL → pc = 0xFFFE. pc = 0xFFFF with sequential advance → 0x0000.
- Call/return nesting, DEPTH = 4:
  - 4 CALLs from pc = 10, 20, 30, 40 → stack_full = 1, stack_err = 0.
  - 5th CALL → no branch, pc += 1, stack_err = 1.
  - 4 RETs → pc = 41, 31, 21, 11; stack_empty = 1.
  - Further RET → pc += 1, stack_err stays 1.
- Stall and halt priority:
  - stall together with a taken JMP → pc holds, and the branch is dropped.
  - halt together with a JMP → state = HALT, pc holds, pc_valid = 0; en and branch requests are then ignored until reset.
